// File: rtl/rcc_seq_pkg.sv
// Shared definitions for the RCC scale sequencer.
//   - seq_state_e    : sequencer FSM states
//   - REG_*          : register word offsets (HADDR[3:2])
//   - STAT_* / CTRL_*: bit positions inside STATUS and CTRL
//   - HTRANS_* / HSIZE_WORD : AHB-Lite encodings used by the slave
//   - RESET_SCALES_DEF     : power-on divider word
//   - scales_valid()       : every live divider field must be non-zero
package rcc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        GATE   = 3'd2,
        UPDATE = 3'd3,
        SETTLE = 3'd4,
        UNGATE = 3'd5
    } seq_state_e;

    localparam logic [1:0] REG_TARGET = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_ACTIVE = 2'd3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_TMO  = 2;
    localparam int STAT_CFG  = 3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [31:0] RESET_SCALES_DEF = 32'h0002_0202;

    // PCLK, TIMCLK and WDOGCLK dividers; a zero ratio would stall that clock.
    function automatic logic scales_valid(input logic [31:0] word);
        return (word[7:0] != 8'h00) && (word[15:8] != 8'h00) && (word[23:16] != 8'h00);
    endfunction

endpackage

// File: rtl/rcc_seq_timer.sv
// Loadable down-counter shared by the DRAIN, GATE and SETTLE phases.
//   HCLK, HRESETn : clock, async active-low reset
//   load          : load load_val this cycle (takes priority over counting)
//   load_val      : value to load
//   expired       : count is zero; the counter holds at zero
module rcc_seq_timer
    import rcc_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/rcc_scale_sequencer.sv
// AHB-Lite slave that owns the RCC divider word and applies a new word
// through a fixed drain / gate / update / settle / ungate sequence.
//
// Ports
//   HCLK, HRESETn           : clock, async active-low reset
//   HSEL..HWDATA            : AHB-Lite slave inputs (word accesses only)
//   HRDATA, HREADYOUT, HRESP: AHB-Lite slave outputs (zero wait state)
//   APB_ACTIVE              : APB bridge busy, must drop before gating
//   scales_out              : active divider word ([7:0] PCLK, [15:8] TIMCLK,
//                             [23:16] WDOGCLK, [31:24] always 0 once updated)
//   pclk_gate_en            : 1 = peripheral clock allowed to run
//   seq_busy                : sequence in progress
//   seq_irq                 : only with RCC_SEQ_IRQ_EN defined;
//                             IRQ_EN & (DONE | ERR_TMO | ERR_CFG), registered
//
// Build option: define RCC_SEQ_IRQ_EN to add the seq_irq output. Without it
// IRQ_EN is still stored and read back but drives nothing.
//
// Registers (HADDR[3:2])
//   0x0 TARGET RW, 0x4 CTRL (START pulse, IRQ_EN), 0x8 STATUS, 0xC ACTIVE RO
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a valid START
// DRAIN  | waiting for APB_ACTIVE low, abort with ERR_TMO after DRAIN_MAX
// GATE   | peripheral clock gated, hold GATE_CYC cycles
// UPDATE | one cycle, scales_out takes the target word
// SETTLE | dividers settling for SETTLE_CYC cycles, still gated
// UNGATE | one cycle, reopen the gate and flag DONE
module rcc_scale_sequencer
    import rcc_seq_pkg::*;
#(
    parameter int          DRAIN_MAX    = 256,
    parameter int          GATE_CYC     = 4,
    parameter int          SETTLE_CYC   = 1024,
    parameter int          CNT_W        = 16,
    parameter logic [31:0] RESET_SCALES = RESET_SCALES_DEF
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [3:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    input  logic        APB_ACTIVE,
    output logic [31:0] scales_out,
    output logic        pclk_gate_en,
    output logic        seq_busy
`ifdef RCC_SEQ_IRQ_EN
   ,output logic        seq_irq
`endif
);

    localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_MAX - 1);
    localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

    // ---------------------------------------------------------------
    // AHB address / data phase
    // ---------------------------------------------------------------
    logic       addr_valid;
    logic       size_ok;
    logic       dp_valid_q;
    logic       dp_write_q;
    logic [1:0] dp_addr_q;
    logic       err1_q;
    logic       err2_q;

    assign addr_valid = HSEL & HREADY & HTRANS[1];
    assign size_ok    = (HSIZE == HSIZE_WORD);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= REG_TARGET;
            err1_q     <= 1'b0;
            err2_q     <= 1'b0;
        end else begin
            dp_valid_q <= addr_valid & size_ok;
            dp_write_q <= HWRITE;
            dp_addr_q  <= HADDR[3:2];
            err1_q     <= addr_valid & ~size_ok;
            err2_q     <= err1_q;
        end
    end

    // Zero-wait slave: the ERROR response is simply HRESP held for the data
    // phase cycle and the one after it.
    assign HREADYOUT = 1'b1;
    assign HRESP     = err1_q | err2_q;

    logic unused_bits;
    assign unused_bits = ^{HADDR[1:0], HTRANS[0]};

    logic wr_target;
    logic wr_ctrl;
    logic wr_status;
    logic rd_access;

    assign wr_target = dp_valid_q & dp_write_q  & (dp_addr_q == REG_TARGET);
    assign wr_ctrl   = dp_valid_q & dp_write_q  & (dp_addr_q == REG_CTRL);
    assign wr_status = dp_valid_q & dp_write_q  & (dp_addr_q == REG_STATUS);
    assign rd_access = dp_valid_q & ~dp_write_q;

    // ---------------------------------------------------------------
    // Sequencer FSM
    // ---------------------------------------------------------------
    seq_state_e       state_q;
    seq_state_e       state_d;
    logic             busy;
    logic             start_req;
    logic             start_go;
    logic             cfg_err;
    logic             set_done;
    logic             set_tmo;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expired;

    logic [31:0]      target_q;
    logic [31:0]      target_d;

    assign busy      = (state_q != IDLE);
    assign start_req = wr_ctrl & HWDATA[CTRL_START];
    assign start_go  = start_req & ~busy &  scales_valid(target_q);
    assign cfg_err   = start_req & ~busy & ~scales_valid(target_q);

    always_comb begin
        state_d  = state_q;
        set_done = 1'b0;
        set_tmo  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_go) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!APB_ACTIVE) begin
                    state_d = GATE;
                end else if (tmr_expired) begin
                    state_d = IDLE;
                    set_tmo = 1'b1;
                end
            end
            GATE: begin
                if (tmr_expired) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                if (tmr_expired) begin
                    state_d = UNGATE;
                end
            end
            UNGATE: begin
                state_d  = IDLE;
                set_done = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The counter is reloaded on every state change; the load value for a
    // state is its dwell time minus one so that expiry marks its last cycle.
    always_comb begin
        tmr_load = (state_d != state_q);
        case (state_d)
            DRAIN:   tmr_val = DRAIN_LD;
            GATE:    tmr_val = GATE_LD;
            SETTLE:  tmr_val = SETTLE_LD;
            default: tmr_val = '0;
        endcase
    end

    rcc_seq_timer #(
        .CNT_W    (CNT_W)
    ) u_timer (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // ---------------------------------------------------------------
    // Configuration and status registers
    // ---------------------------------------------------------------
    logic [31:0] scales_q;
    logic [31:0] scales_d;
    logic        gate_q;
    logic        gate_d;
    logic        irq_en_q;
    logic        irq_en_d;
    logic [3:1]  stat_q;
    logic [3:1]  stat_d;
    logic [3:1]  stat_set;
    logic [3:1]  stat_clr;

    always_comb begin
        target_d = target_q;
        if (wr_target && !busy) begin
            target_d = HWDATA;
        end
    end

    assign irq_en_d = wr_ctrl ? HWDATA[CTRL_IRQ_EN] : irq_en_q;

    assign scales_d = (state_q == UPDATE) ? {8'h00, target_q[23:0]} : scales_q;

    // Gate is registered off the next state so it is glitch-free and low for
    // exactly GATE + UPDATE + SETTLE.
    assign gate_d = !(state_d inside {GATE, UPDATE, SETTLE});

    always_comb begin
        stat_set           = '0;
        stat_set[STAT_DONE] = set_done;
        stat_set[STAT_TMO]  = set_tmo;
        stat_set[STAT_CFG]  = cfg_err;
        stat_clr           = wr_status ? HWDATA[3:1] : 3'b000;
        // A hardware set in the same cycle as a W1C keeps the bit set.
        stat_d             = (stat_q & ~stat_clr) | stat_set;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            target_q <= RESET_SCALES;
            scales_q <= RESET_SCALES;
            gate_q   <= 1'b1;
            irq_en_q <= 1'b0;
            stat_q   <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            scales_q <= scales_d;
            gate_q   <= gate_d;
            irq_en_q <= irq_en_d;
            stat_q   <= stat_d;
        end
    end

    assign scales_out   = scales_q;
    assign pclk_gate_en = gate_q;
    assign seq_busy     = busy;

`ifdef RCC_SEQ_IRQ_EN
    logic irq_q;
    logic irq_d;

    assign irq_d = irq_en_d & (|stat_d);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign seq_irq = irq_q;
`endif

    // ---------------------------------------------------------------
    // Read mux (data phase)
    // ---------------------------------------------------------------
    always_comb begin
        HRDATA = '0;
        if (rd_access) begin
            case (dp_addr_q)
                REG_TARGET: HRDATA = target_q;
                REG_CTRL:   HRDATA = {30'h0, irq_en_q, 1'b0};
                REG_STATUS: HRDATA = {28'h0, stat_q, busy};
                REG_ACTIVE: HRDATA = scales_q;
                default:    HRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_rcc_scale_sequencer.sv
module tb_rcc_scale_sequencer;

    localparam int          P_DRAIN  = 256;
    localparam int          P_GATE   = 4;
    localparam int          P_SETTLE = 1024;
    localparam logic [31:0] P_RESET  = 32'h0002_0202;

    localparam logic [3:0] A_TARGET = 4'h0;
    localparam logic [3:0] A_CTRL   = 4'h4;
    localparam logic [3:0] A_STATUS = 4'h8;
    localparam logic [3:0] A_ACTIVE = 4'hC;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [3:0]  HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b010;
    logic        HREADY = 1'b1;
    logic [31:0] HWDATA = '0;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        APB_ACTIVE = 1'b0;
    logic [31:0] scales_out;
    logic        pclk_gate_en;
    logic        seq_busy;
`ifdef RCC_SEQ_IRQ_EN
    logic        seq_irq;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: software-visible state only.
    logic [31:0] m_target = P_RESET;
    logic [31:0] m_active = P_RESET;
    logic        m_done = 1'b0;
    logic        m_tmo = 1'b0;
    logic        m_cfg = 1'b0;
    logic        m_irq_en = 1'b0;

    always #5 HCLK = ~HCLK;

    rcc_scale_sequencer dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .HSEL         (HSEL),
        .HADDR        (HADDR),
        .HTRANS       (HTRANS),
        .HWRITE       (HWRITE),
        .HSIZE        (HSIZE),
        .HREADY       (HREADY),
        .HWDATA       (HWDATA),
        .HRDATA       (HRDATA),
        .HREADYOUT    (HREADYOUT),
        .HRESP        (HRESP),
        .APB_ACTIVE   (APB_ACTIVE),
        .scales_out   (scales_out),
        .pclk_gate_en (pclk_gate_en),
        .seq_busy     (seq_busy)
`ifdef RCC_SEQ_IRQ_EN
       ,.seq_irq      (seq_irq)
`endif
    );

    function automatic logic [31:0] exp_status();
        return {28'h0, m_cfg, m_tmo, m_done, 1'b0};
    endfunction

    function automatic logic [31:0] rand_valid_target();
        logic [31:0] w;
        w[7:0]   = 8'($urandom_range(1, 255));
        w[15:8]  = 8'($urandom_range(1, 255));
        w[23:16] = 8'($urandom_range(1, 255));
        w[31:24] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    // Returns one cycle after the data phase; resp = {HRESP in D+1, HRESP in D}.
    task automatic ahb_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [2:0] size, output logic [1:0] resp);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr; HSIZE = size;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010; HWDATA = data;
        resp[0] = HRESP;
        @(posedge HCLK); #1;
        resp[1] = HRESP;
    endtask

    task automatic ahb_read(input logic [3:0] addr, output logic [31:0] data);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        tests_run++;
        if (scales_out !== P_RESET || pclk_gate_en !== 1'b1 || seq_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: scales=%h gate=%b busy=%b, want %h 1 0", scales_out, pclk_gate_en, seq_busy, P_RESET);
        end
        tests_run++;
        if (HRDATA !== 32'h0 || HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_bus: hrdata=%h hresp=%b hreadyout=%b, want 0 0 1", HRDATA, HRESP, HREADYOUT);
        end
        HRESETn = 1'b1;
        ahb_read(A_ACTIVE, rd);
        tests_run++;
        if (rd !== P_RESET) begin
            tests_failed++;
            $display("FAIL reset_active: got %h want %h", rd, P_RESET);
        end
        ahb_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_status: got %h want 0", rd);
        end
        ahb_read(A_TARGET, rd);
        tests_run++;
        if (rd !== P_RESET) begin
            tests_failed++;
            $display("FAIL reset_target: got %h want %h", rd, P_RESET);
        end
        ahb_read(A_CTRL, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %h want 0", rd);
        end
    endtask

    task automatic test_nominal(input int iters);
        logic [31:0] rd;
        logic [1:0]  resp;
        for (int it = 0; it < iters; it++) begin
            logic [31:0] tgt;
            int k, idx, busy_cnt, gate_low, first_gate, first_scale;
            do tgt = rand_valid_target(); while (tgt[23:0] == m_active[23:0]);
            k = (it == 0) ? 0 : $urandom_range(1, 30);
            ahb_write(A_TARGET, tgt, 3'b010, resp);
            m_target = tgt;
            ahb_read(A_TARGET, rd);
            tests_run++;
            if (rd !== m_target) begin
                tests_failed++;
                $display("FAIL nominal_target_rd: got %h want %h", rd, m_target);
            end
            APB_ACTIVE = 1'b1;
            ahb_write(A_CTRL, 32'h1 | (32'(m_irq_en) << 1), 3'b010, resp);
            idx = 0; busy_cnt = 0; gate_low = 0; first_gate = -1; first_scale = -1;
            while (seq_busy === 1'b1 && idx < 3000) begin
                idx++;
                busy_cnt++;
                if (idx == k + 1) APB_ACTIVE = 1'b0;
                if (idx == k + 3) APB_ACTIVE = 1'b1;
                if (pclk_gate_en === 1'b0) begin
                    gate_low++;
                    if (first_gate < 0) first_gate = idx;
                end
                if (first_scale < 0 && scales_out === {8'h00, tgt[23:0]}) first_scale = idx;
                @(posedge HCLK); #1;
            end
            APB_ACTIVE = 1'b0;
            m_active = {8'h00, tgt[23:0]};
            m_done = 1'b1;
            tests_run++;
            if (busy_cnt !== 1 + k + P_GATE + 1 + P_SETTLE + 1) begin
                tests_failed++;
                $display("FAIL nominal_latency: drain=%0d busy cycles %0d want %0d", k, busy_cnt, 1 + k + P_GATE + 1 + P_SETTLE + 1);
            end
            tests_run++;
            if (gate_low !== P_GATE + 1 + P_SETTLE || first_gate !== k + 2) begin
                tests_failed++;
                $display("FAIL nominal_gate: low %0d from %0d, want %0d from %0d", gate_low, first_gate, P_GATE + 1 + P_SETTLE, k + 2);
            end
            tests_run++;
            if (first_scale !== k + P_GATE + 3) begin
                tests_failed++;
                $display("FAIL nominal_update_time: got %0d want %0d", first_scale, k + P_GATE + 3);
            end
            tests_run++;
            if (pclk_gate_en !== 1'b1 || scales_out !== m_active) begin
                tests_failed++;
                $display("FAIL nominal_end: gate=%b scales=%h want 1 %h", pclk_gate_en, scales_out, m_active);
            end
            ahb_read(A_STATUS, rd);
            tests_run++;
            if (rd !== exp_status()) begin
                tests_failed++;
                $display("FAIL nominal_status: got %h want %h", rd, exp_status());
            end
            ahb_read(A_ACTIVE, rd);
            tests_run++;
            if (rd !== m_active) begin
                tests_failed++;
                $display("FAIL nominal_active: got %h want %h", rd, m_active);
            end
            ahb_write(A_STATUS, 32'h2, 3'b010, resp);
            m_done = 1'b0;
            ahb_read(A_STATUS, rd);
            tests_run++;
            if (rd !== exp_status()) begin
                tests_failed++;
                $display("FAIL nominal_w1c: got %h want %h", rd, exp_status());
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        logic [1:0]  resp;
        int idx = 0;
        int gate_low = 0;
        APB_ACTIVE = 1'b1;
        ahb_write(A_CTRL, 32'h1 | (32'(m_irq_en) << 1), 3'b010, resp);
        while (seq_busy === 1'b1 && idx < 1000) begin
            idx++;
            if (pclk_gate_en !== 1'b1) gate_low++;
            @(posedge HCLK); #1;
        end
        APB_ACTIVE = 1'b0;
        m_tmo = 1'b1;
        tests_run++;
        if (idx !== P_DRAIN) begin
            tests_failed++;
            $display("FAIL timeout_cycles: got %0d want %0d", idx, P_DRAIN);
        end
        tests_run++;
        if (gate_low !== 0 || scales_out !== m_active) begin
            tests_failed++;
            $display("FAIL timeout_unchanged: gate low %0d scales %h, want 0 %h", gate_low, scales_out, m_active);
        end
        ahb_read(A_STATUS, rd);
        tests_run++;
        if (rd !== exp_status()) begin
            tests_failed++;
            $display("FAIL timeout_status: got %h want %h", rd, exp_status());
        end
        ahb_write(A_STATUS, 32'h4, 3'b010, resp);
        m_tmo = 1'b0;
    endtask

    task automatic test_cfg_err();
        logic [31:0] rd;
        logic [1:0]  resp;
        for (int it = 0; it < 3; it++) begin
            logic [31:0] tgt;
            tgt = rand_valid_target();
            tgt[it*8 +: 8] = 8'h00;
            if (it == 0) tgt = 32'h0000_0208;
            ahb_write(A_TARGET, tgt, 3'b010, resp);
            m_target = tgt;
            ahb_write(A_CTRL, 32'h1 | (32'(m_irq_en) << 1), 3'b010, resp);
            m_cfg = 1'b1;
            tests_run++;
            if (seq_busy !== 1'b0 || pclk_gate_en !== 1'b1 || scales_out !== m_active) begin
                tests_failed++;
                $display("FAIL cfg_no_start: busy=%b gate=%b scales=%h want 0 1 %h", seq_busy, pclk_gate_en, scales_out, m_active);
            end
            ahb_read(A_STATUS, rd);
            tests_run++;
            if (rd !== exp_status()) begin
                tests_failed++;
                $display("FAIL cfg_status: got %h want %h", rd, exp_status());
            end
            ahb_write(A_STATUS, 32'h8, 3'b010, resp);
            m_cfg = 1'b0;
            ahb_read(A_STATUS, rd);
            tests_run++;
            if (rd !== exp_status()) begin
                tests_failed++;
                $display("FAIL cfg_w1c: got %h want %h", rd, exp_status());
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] rd;
        logic [31:0] tgt;
        logic [1:0]  resp;
        int idx = 0;
        do tgt = rand_valid_target(); while (tgt[23:0] == m_active[23:0]);
        ahb_write(A_TARGET, tgt, 3'b010, resp);
        m_target = tgt;
        APB_ACTIVE = 1'b0;
        ahb_write(A_CTRL, 32'h1 | (32'(m_irq_en) << 1), 3'b010, resp);
        repeat (100) @(posedge HCLK);
        #1;
        ahb_write(A_TARGET, 32'h00FF_FFFF, 3'b010, resp);
        tests_run++;
        if (resp !== 2'b00) begin
            tests_failed++;
            $display("FAIL busy_target_resp: got %b want 00", resp);
        end
        ahb_write(A_CTRL, 32'h1 | (32'(m_irq_en) << 1), 3'b010, resp);
        ahb_write(A_TARGET, 32'h0011_2233, 3'b000, resp);
        tests_run++;
        if (resp !== 2'b11) begin
            tests_failed++;
            $display("FAIL busy_byte_err: hresp pair %b want 11", resp);
        end
        @(posedge HCLK); #1;
        tests_run++;
        if (HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_two_cycles: hresp=%b hreadyout=%b want 0 1", HRESP, HREADYOUT);
        end
        while (seq_busy === 1'b1 && idx < 3000) begin
            idx++;
            @(posedge HCLK); #1;
        end
        m_active = {8'h00, tgt[23:0]};
        m_done = 1'b1;
        tests_run++;
        if (seq_busy !== 1'b0 || scales_out !== m_active) begin
            tests_failed++;
            $display("FAIL busy_complete: busy=%b scales=%h want 0 %h", seq_busy, scales_out, m_active);
        end
        ahb_read(A_TARGET, rd);
        tests_run++;
        if (rd !== m_target) begin
            tests_failed++;
            $display("FAIL busy_target_kept: got %h want %h", rd, m_target);
        end
        ahb_read(A_STATUS, rd);
        tests_run++;
        if (rd !== exp_status()) begin
            tests_failed++;
            $display("FAIL busy_status: got %h want %h", rd, exp_status());
        end
        ahb_write(A_STATUS, 32'h2, 3'b010, resp);
        m_done = 1'b0;
        ahb_write(A_TARGET, 32'h0005_0505, 3'b001, resp);
        tests_run++;
        if (resp !== 2'b11) begin
            tests_failed++;
            $display("FAIL idle_half_err: hresp pair %b want 11", resp);
        end
        ahb_read(A_TARGET, rd);
        tests_run++;
        if (rd !== m_target) begin
            tests_failed++;
            $display("FAIL idle_err_no_effect: got %h want %h", rd, m_target);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [1:0]  resp;
        int idx = 0;
        ahb_write(A_TARGET, 32'h0004_0308, 3'b010, resp);
        APB_ACTIVE = 1'b0;
        ahb_write(A_CTRL, 32'h1, 3'b010, resp);
        while (pclk_gate_en === 1'b1 && idx < 20) begin
            idx++;
            @(posedge HCLK); #1;
        end
        tests_run++;
        if (pclk_gate_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_gate_drop: gate=%b want 0", pclk_gate_en);
        end
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        tests_run++;
        if (scales_out !== P_RESET || pclk_gate_en !== 1'b1 || seq_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: scales=%h gate=%b busy=%b want %h 1 0", scales_out, pclk_gate_en, seq_busy, P_RESET);
        end
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        m_target = P_RESET; m_active = P_RESET; m_irq_en = 1'b0;
        m_done = 1'b0; m_tmo = 1'b0; m_cfg = 1'b0;
        ahb_read(A_TARGET, rd);
        tests_run++;
        if (rd !== m_target) begin
            tests_failed++;
            $display("FAIL rstmid_target: got %h want %h", rd, m_target);
        end
        ahb_read(A_STATUS, rd);
        tests_run++;
        if (rd !== exp_status() || pclk_gate_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_status: got %h gate=%b want %h 1", rd, pclk_gate_en, exp_status());
        end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        logic [1:0]  resp;
        logic [31:0] tgt;
        int idx = 0;
        ahb_write(A_CTRL, 32'h2, 3'b010, resp);
        m_irq_en = 1'b1;
        ahb_read(A_CTRL, rd);
        tests_run++;
        if (rd !== {30'h0, m_irq_en, 1'b0}) begin
            tests_failed++;
            $display("FAIL ctrl_readback: got %h want %h", rd, {30'h0, m_irq_en, 1'b0});
        end
`ifdef RCC_SEQ_IRQ_EN
        tests_run++;
        if (seq_irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_idle: got %b want 0", seq_irq);
        end
        do tgt = rand_valid_target(); while (tgt[23:0] == m_active[23:0]);
        ahb_write(A_TARGET, tgt, 3'b010, resp);
        m_target = tgt;
        ahb_write(A_CTRL, 32'h3, 3'b010, resp);
        while (seq_busy === 1'b1 && idx < 3000) begin
            idx++;
            @(posedge HCLK); #1;
        end
        m_active = {8'h00, tgt[23:0]};
        m_done = 1'b1;
        tests_run++;
        if (seq_irq !== (m_irq_en & m_done)) begin
            tests_failed++;
            $display("FAIL irq_on_done: got %b want %b", seq_irq, m_irq_en & m_done);
        end
        ahb_write(A_STATUS, 32'h2, 3'b010, resp);
        m_done = 1'b0;
        tests_run++;
        if (seq_irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_w1c: got %b want 0", seq_irq);
        end
`else
        tgt = m_target;
        idx = 0;
        resp = 2'b00;
        if (idx != 0 || tgt !== m_target || resp != 2'b00) $display("unexpected bench state");
`endif
    endtask

    initial begin
        test_reset();
        test_nominal(3);
        test_timeout();
        test_cfg_err();
        test_busy_ignore();
        test_irq();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
